// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for 4-way mux arbiters: sizes, FSM encodings, grant helper.
// Combinational only; no latency or backpressure of its own.
package mux_arb_pkg;

   localparam int NREQ  = 4;
   localparam int SEL_W = 2;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_OWN  = 2'b01;
   localparam logic [1:0] ST_GAP  = 2'b10;

   function automatic logic [NREQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
      return NREQ'(1) << idx;
   endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between the requesting blocks and the mux arbiter.
// master = requester side (drives req), slave = arbiter side (drives grant and select).
interface mux4_rr_arbiter_if;
   import mux_arb_pkg::*;

   logic [NREQ-1:0]  req;
   logic [NREQ-1:0]  gnt;
   logic [SEL_W-1:0] sel;
   logic             busy;
   logic             timeout;

   modport master (output req, input gnt, sel, busy, timeout);
   modport slave  (input req, output gnt, sel, busy, timeout);
endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Rotating-priority pick of 4 requesters: first set bit after i_last, wrapping.
// Purely combinational, zero latency; o_valid low when no request is set.
module rr_pick4
   import mux_arb_pkg::*;
(
   input  logic [NREQ-1:0]  i_req,
   input  logic [SEL_W-1:0] i_last,
   output logic [SEL_W-1:0] o_winner,
   output logic             o_valid
);

   logic [SEL_W-1:0] w_idx;

   // Scan farthest-first so the nearest candidate after i_last overwrites the rest.
   always_comb begin
      o_winner = '0;
      o_valid  = 1'b0;
      w_idx    = '0;
      for (int k = NREQ; k >= 1; k--) begin
         w_idx = i_last + SEL_W'(k);
         if (i_req[w_idx]) begin
            o_winner = w_idx;
            o_valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of a shared 4:1 mux: grants one requester, caps hold time,
// and idles one cycle between owners so select never moves under a live grant.
module mux4_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 3
)
(
   input  logic              clk,
   input  logic              rst_n,
   mux4_rr_arbiter_if.slave  bus
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   logic [1:0]       r_state;
   logic [NREQ-1:0]  r_gnt;
   logic [SEL_W-1:0] r_sel;
   logic [SEL_W-1:0] r_last;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;
   logic             r_timeout;

   logic [SEL_W-1:0] w_winner;
   logic             w_valid;

   rr_pick4 u_pick (
      .i_req    (bus.req),
      .i_last   (r_last),
      .o_winner (w_winner),
      .o_valid  (w_valid)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_gnt     <= '0;
         r_sel     <= '0;
         r_last    <= SEL_W'(NREQ - 1);
         r_cnt     <= '0;
         r_busy    <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_GAP: begin
               r_timeout <= 1'b0;
               if (w_valid) begin
                  r_state <= ST_OWN;
                  r_gnt   <= onehot4(w_winner);
                  r_sel   <= w_winner;
                  r_last  <= w_winner;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end else begin
                  r_state <= ST_IDLE;
                  r_gnt   <= '0;
                  r_busy  <= 1'b0;
               end
            end
            ST_OWN: begin
               // Compare before increment: the counter never wraps.
               if (!bus.req[r_last]) begin
                  r_state   <= ST_GAP;
                  r_gnt     <= '0;
                  r_busy    <= 1'b0;
                  r_timeout <= 1'b0;
               end else if (r_cnt == HOLD_LAST) begin
                  r_state   <= ST_GAP;
                  r_gnt     <= '0;
                  r_busy    <= 1'b0;
                  r_timeout <= 1'b1;
               end else begin
                  r_cnt     <= r_cnt + 1'b1;
                  r_timeout <= 1'b0;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_gnt     <= '0;
               r_busy    <= 1'b0;
               r_timeout <= 1'b0;
            end
         endcase
      end
   end

   assign bus.gnt     = r_gnt;
   assign bus.sel     = r_sel;
   assign bus.busy    = r_busy;
   assign bus.timeout = r_timeout;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed and random stimulus for mux4_rr_arbiter against an owner/hold-time model.
module tb_mux4_rr_arbiter;
   localparam int MAX_HOLD = 8;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   mux4_rr_arbiter_if bus ();

   mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model: who owns the mux, for how many cycles so far, and who owned it last.
   int       m_owner;
   int       m_last;
   int       m_held;
   int       m_sel;
   bit       m_timeout;
   logic [3:0] p_gnt;
   logic [1:0] p_sel;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input logic [3:0] r, input logic rst);
      if (!rst) begin
         m_owner = -1; m_last = 3; m_sel = 0; m_timeout = 0; m_held = 0;
      end else if (m_owner >= 0) begin
         if (!r[m_owner]) begin
            m_owner = -1; m_timeout = 0;
         end else if (m_held == MAX_HOLD) begin
            m_owner = -1; m_timeout = 1;
         end else begin
            m_held++; m_timeout = 0;
         end
      end else begin
         m_timeout = 0;
         for (int k = 1; k <= 4; k++) begin
            int i;
            i = (m_last + k) % 4;
            if (m_owner < 0 && r[i]) begin
               m_owner = i; m_last = i; m_sel = i; m_held = 1;
            end
         end
      end
   endtask

   task automatic cycle();
      logic [3:0] r_s;
      logic       rst_s;
      logic [3:0] exp_gnt;
      @(posedge clk);
      r_s = bus.req; rst_s = rst_n;
      model_step(r_s, rst_s);
      @(negedge clk);
      exp_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      chk("gnt", bus.gnt, exp_gnt);
      chk("sel", {2'b00, bus.sel}, 4'(m_sel));
      chk("busy", {3'b000, bus.busy}, {3'b000, m_owner >= 0});
      chk("timeout", {3'b000, bus.timeout}, {3'b000, m_timeout});
      chk("gnt_onehot0", {3'b000, $onehot0(bus.gnt)}, 4'b0001);
      if (rst_s && bus.sel !== p_sel)
         chk("sel_moves_only_on_new_grant", {2'b00, p_gnt == 4'b0 && bus.gnt != 4'b0}, 4'b0001);
      if (p_gnt != 4'b0 && bus.gnt != 4'b0)
         chk("sel_stable_under_grant", {2'b00, bus.sel}, {2'b00, p_sel});
      if (bus.timeout === 1'b1)
         chk("timeout_after_release", {3'b000, p_gnt != 4'b0 && bus.gnt == 4'b0}, 4'b0001);
      p_gnt = bus.gnt; p_sel = bus.sel;
   endtask

   task automatic run(input logic [3:0] r, input int n);
      bus.req = r;
      for (int c = 0; c < n; c++) cycle();
   endtask

   initial begin
      checks = 0; errors = 0;
      m_owner = -1; m_last = 3; m_sel = 0; m_timeout = 0; m_held = 0;
      p_gnt = 4'b0; p_sel = 2'b0;
      rst_n = 1'b0;
      bus.req = 4'b1111;

      // Reset held with full contention, then index 0 wins first.
      run(4'b1111, 2);
      chk("reset_gnt", bus.gnt, 4'b0000);
      chk("reset_sel", {2'b00, bus.sel}, 4'b0000);
      rst_n = 1'b1;
      run(4'b1111, 1);
      chk("first_grant", bus.gnt, 4'b0001);
      // Full rotation with 8-cycle holds and one-cycle gaps.
      run(4'b1111, 40);
      run(4'b0000, 3);

      // Short request released by dropping req.
      run(4'b0100, 3);
      chk("short_sel", {2'b00, bus.sel}, 4'b0010);
      run(4'b0000, 2);

      // Lone hog is re-granted after each gap.
      run(4'b0010, 30);
      run(4'b0000, 2);

      // Pointer skip: owner 0 times out, index 3 is next.
      run(4'b0001, 2);
      run(4'b1001, 7);
      chk("skip_gap", bus.gnt, 4'b0000);
      run(4'b1001, 1);
      chk("skip_gnt", bus.gnt, 4'b1000);
      chk("skip_sel", {2'b00, bus.sel}, 4'b0011);
      run(4'b0000, 2);

      // Reset mid-ownership, then a fresh full hold.
      run(4'b0100, 6);
      rst_n = 1'b0;
      run(4'b0100, 1);
      chk("midown_reset_gnt", bus.gnt, 4'b0000);
      rst_n = 1'b1;
      run(4'b0100, 20);

      // Random requests with occasional resets.
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 5) == 0) bus.req = 4'($urandom_range(0, 15));
         rst_n = ($urandom_range(0, 60) != 0);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
